elevator_request_scheduler: RTL and testbench
=============================================

# elevator_request_scheduler

Collects floor calls for a single elevator car, holds them in a pending-request bitmap, and issues one target floor at a time to the elevator motion state machine using a collective (SCAN) policy. Continues in the current travel direction while calls remain ahead, then reverses. Holds the door open for a fixed dwell on each arrival. Sits between the `ui_in` call inputs and the motion controller's `requested_floor` input, and observes the controller's `current_floor`.

## Interface
- `NUM_FLOORS`, 10: number of served floors (0..NUM_FLOORS-1), max 16.
- `DOOR_DWELL`, 32'd20000000: door-open duration in clock cycles, ≥1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `call_valid` input 1: call strobe; sampled every cycle.
- `call_floor` input 4: floor being called; qualified by `call_valid`.
- `current_floor` input 4: car position reported by the motion controller.
- `target_floor` output 4: registered; drives the motion controller's `requested_floor`.
- `pending` output NUM_FLOORS: registered bitmap of unserved calls.
- `dir_up` output 1: registered travel direction, 1 = up.
- `door_open` output 1: registered; high while the door dwell runs.

## Operation
- States: IDLE, SERVE, DOOR.
- Reset values: state IDLE, `pending`=0, `target_floor`=0, `dir_up`=1, `door_open`=0, dwell counter 0. Reset asserted mid-operation discards all calls and the dwell immediately.
- Call latch: on `call_valid` with `call_floor` < NUM_FLOORS, set `pending[call_floor]` at the next edge.
  - Calls to floors ≥ NUM_FLOORS are ignored.
  - A call for a floor already pending has no effect.
  - Exception: when `call_floor` == `current_floor` in IDLE or DOOR, the call is not latched. In IDLE it goes to DOOR. In DOOR it restarts the dwell counter.
- IDLE: `target_floor` = `current_floor` and `door_open`=0. When `pending` ≠ 0:
  - Pending floor above with `dir_up`=1: target = lowest pending floor > current.
  - Pending floor below with `dir_up`=0: target = highest pending floor < current.
  - Otherwise: flip `dir_up` and select from the other side.
  - Register the target and go to SERVE.
- SERVE, retargeting: if a newly pending floor f lies strictly between `current_floor` and `target_floor` in the travel direction, `target_floor` becomes f. Calls behind the car or beyond the target only update `pending`.
- SERVE, arrival: when `current_floor` == `target_floor`, clear `pending[target_floor]`, set `door_open`, load the dwell counter, and go to DOOR. A call to the same floor in that cycle is absorbed, so its bit stays cleared.
- DOOR: `target_floor` holds `current_floor`. The counter counts DOOR_DWELL cycles. At expiry, clear `door_open` and go to IDLE.
- Arithmetic: floor compares are 4-bit unsigned. The dwell counter is 32-bit and never wraps; it stops at its terminal count.

## Timing
- Call at cycle N (`call_valid` high in N): `pending` bit visible in N+1.
- From IDLE: `target_floor` and state SERVE valid in N+2.
- Retarget: new `target_floor` valid the cycle after the `pending` bit sets.
- Arrival detected in cycle A: `door_open`=1 and the `pending` bit cleared from A+1. `door_open` stays high exactly DOOR_DWELL cycles, falling at A+1+DOOR_DWELL. IDLE re-evaluation occurs in that same cycle; the next target is possible one cycle later.
- Reopen call during DOOR at cycle M: `door_open` stays high until M+1+DOOR_DWELL.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Test plan
Use DOOR_DWELL=4, with a bench model that steps `current_floor` by 1 every 8 cycles toward `target_floor`.
- Reset: hold `rst_n`=0, pulse calls → all outputs at reset values. Release → IDLE, `target_floor`=0, `door_open`=0.
- Single call: car at 0, call 5 → `pending`=10'b0000100000 at N+1, `target_floor`=5 at N+2. Arrival → `pending`=0, `door_open` high 4 cycles, `target_floor` stays 5.
- Retarget: car at 1 heading to 7, call 4 while `current_floor`=2 → `target_floor`=4 next cycle. After the dwell → `target_floor`=7, `dir_up`=1.
- Reversal: car at 6 going up, pending {2, 8}, call 3 during travel → order 8, then `dir_up`=0, then 3, then 2.
- Same-floor and boundary: car idle at 4, call 4 → no `pending` bit, `door_open` for 4 cycles. Call 4 again at dwell cycle 3 → `door_open` extends to 4 cycles after the re-call. Call 12 → ignored, `pending` unchanged.
- Reset mid-SERVE: assert `rst_n` low while moving with `pending`≠0 → `pending`=0, `target_floor`=0, `dir_up`=1 asynchronously.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// Collective (SCAN) request scheduler for a single elevator car: latches floor calls,
// issues one target floor at a time, and times the door dwell on each arrival.
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS = 10,
    parameter logic [31:0] DOOR_DWELL = 32'd20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [3:0]            call_floor,
    input  logic [3:0]            current_floor,
    output logic [3:0]            target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open
);
    typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;

    localparam logic [4:0]  NF         = 5'(NUM_FLOORS);
    localparam logic [31:0] DWELL_LAST = DOOR_DWELL - 32'd1;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [3:0]            target_q, target_d;
    logic                  dir_up_q, dir_up_d;
    logic                  door_open_q, door_open_d;
    logic [31:0]           dwell_q, dwell_d;

    logic                  call_ok, same_call, arrive, expire;
    logic [NUM_FLOORS-1:0] call_oh, tgt_oh, above, below, ahead;
    logic [3:0]            above_lo, below_hi, ahead_sel;

    function automatic logic [3:0] lowest(input logic [NUM_FLOORS-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (m[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [3:0] highest(input logic [NUM_FLOORS-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i]) r = 4'(i);
        return r;
    endfunction

    assign call_ok   = call_valid && ({1'b0, call_floor} < NF);
    assign same_call = call_ok && (call_floor == current_floor);
    assign arrive    = (current_floor == target_q);
    assign expire    = (dwell_q == DWELL_LAST);

    // "ahead" = pending floors strictly between the car and its target, in the travel direction
    always_comb begin
        call_oh = '0;
        tgt_oh  = '0;
        above   = '0;
        below   = '0;
        ahead   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            call_oh[i] = call_ok && (call_floor == 4'(i));
            tgt_oh[i]  = (target_q == 4'(i));
            above[i]   = pending_q[i] && (4'(i) > current_floor);
            below[i]   = pending_q[i] && (4'(i) < current_floor);
            ahead[i]   = pending_q[i] && (dir_up_q ? (4'(i) > current_floor && 4'(i) < target_q)
                                                   : (4'(i) < current_floor && 4'(i) > target_q));
        end
    end

    assign above_lo  = lowest(above);
    assign below_hi  = highest(below);
    assign ahead_sel = dir_up_q ? lowest(ahead) : highest(ahead);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            target_q    <= '0;
            dir_up_q    <= 1'b1;
            door_open_q <= 1'b0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            dir_up_q    <= dir_up_d;
            door_open_q <= door_open_d;
            dwell_q     <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (same_call) state_d = DOOR;
                     else if (|pending_q) state_d = SERVE;
            SERVE:   if (arrive) state_d = DOOR;
            DOOR:    if (!same_call && expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d   = pending_q | call_oh;
        target_d    = target_q;
        dir_up_d    = dir_up_q;
        door_open_d = door_open_q;
        dwell_d     = dwell_q;
        case (state_q)
            IDLE: begin
                target_d    = current_floor;
                door_open_d = 1'b0;
                if (same_call) begin
                    pending_d   = pending_q;
                    door_open_d = 1'b1;
                    dwell_d     = '0;
                end else if (|pending_q) begin
                    // A lone call at the current floor keeps target = current and arrives next cycle
                    if (dir_up_q && |above) begin
                        target_d = above_lo;
                    end else if (!dir_up_q && |below) begin
                        target_d = below_hi;
                    end else if (|above) begin
                        dir_up_d = 1'b1;
                        target_d = above_lo;
                    end else if (|below) begin
                        dir_up_d = 1'b0;
                        target_d = below_hi;
                    end
                end
            end
            SERVE: begin
                if (arrive) begin
                    pending_d   = (pending_q | call_oh) & ~tgt_oh;
                    door_open_d = 1'b1;
                    dwell_d     = '0;
                end else if (|ahead) begin
                    target_d = ahead_sel;
                end
            end
            DOOR: begin
                target_d = current_floor;
                if (same_call) begin
                    pending_d = pending_q;
                    dwell_d   = '0;
                end else if (expire) begin
                    door_open_d = 1'b0;
                end else begin
                    dwell_d = dwell_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    assign target_floor = target_q;
    assign pending      = pending_q;
    assign dir_up       = dir_up_q;
    assign door_open    = door_open_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: cycle vectors with directly driven car position,
// then motion-model sequences checking arrival order, plus an asynchronous reset check.
module tb_elevator_request_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       call_valid = 1'b0;
    logic [3:0] call_floor = 4'd0;
    logic [3:0] current_floor = 4'd0;
    logic [3:0] target_floor;
    logic [9:0] pending;
    logic       dir_up;
    logic       door_open;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.NUM_FLOORS(10), .DOOR_DWELL(32'd4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .target_floor  (target_floor),
        .pending       (pending),
        .dir_up        (dir_up),
        .door_open     (door_open)
    );

    typedef struct {
        logic [3:0] cur;
        logic       cv;
        logic [3:0] cf;
        logic [9:0] pend;
        logic [3:0] tgt;
        logic       dir;
        logic       door;
    } vec_t;

    typedef struct {
        logic [9:0] pend;
        logic [3:0] tgt;
        logic       dir;
        logic       door;
    } exp_t;

    typedef struct {
        logic [3:0] floor;
        logic       dir;
    } arr_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    arr_t arr_q[$];
    int   passed = 0;
    int   total = 0;
    logic door_prev = 1'b0;
    int   mv_cnt = 0;

    function automatic vec_t mk(input int cur, input bit cv, input int cf, input int pend,
                                input int tgt, input bit dir, input bit door);
        vec_t v;
        v.cur  = 4'(cur);
        v.cv   = cv;
        v.cf   = 4'(cf);
        v.pend = 10'(pend);
        v.tgt  = 4'(tgt);
        v.dir  = dir;
        v.door = door;
        return v;
    endfunction

    function automatic arr_t mka(input int floor, input bit dir);
        arr_t a;
        a.floor = 4'(floor);
        a.dir   = dir;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One cycle of the motion model: checks door-opening events against the arrival
    // scoreboard, then steps the car one floor toward target every 8 cycles.
    task automatic tick();
        arr_t a;
        @(negedge clk);
        if (door_open && !door_prev) begin
            if (arr_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_arrival: door opened at floor %0d, expected no arrival", current_floor);
            end else begin
                a = arr_q.pop_front();
                chk("arrival {cur,target,dir}", 32'({current_floor, target_floor, dir_up}),
                    32'({a.floor, a.floor, a.dir}));
            end
        end
        door_prev = door_open;
        mv_cnt++;
        if (mv_cnt >= 8) begin
            mv_cnt = 0;
            if (!door_open && current_floor != target_floor)
                current_floor = (target_floor > current_floor) ? current_floor + 4'd1 : current_floor - 4'd1;
        end
    endtask

    task automatic run_arrivals(input string name, input int bound);
        int n = 0;
        while (arr_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        if (arr_q.size() > 0) begin
            total++;
            $display("FAIL %s: timeout with %0d arrivals outstanding, expected 0", name, arr_q.size());
            arr_q.delete();
        end
    endtask

    task automatic run_to_floor(input string name, input logic [3:0] floor, input int bound);
        int n = 0;
        while (current_floor != floor && n < bound) begin
            tick();
            n++;
        end
        if (current_floor != floor) begin
            total++;
            $display("FAIL %s: timeout, car at %0d, expected %0d", name, current_floor, floor);
        end
    endtask

    task automatic do_reset(input logic [3:0] start_floor);
        @(negedge clk);
        rst_n = 1'b0;
        call_valid = 1'b0;
        current_floor = start_floor;
        @(negedge clk);
        rst_n = 1'b1;
        door_prev = 1'b0;
        mv_cnt = 0;
    endtask

    initial begin
        exp_t e;

        // Reset held with calls pulsing
        current_floor = 4'd0;
        repeat (2) @(negedge clk);
        call_valid = 1'b1;
        call_floor = 4'd5;
        repeat (3) @(negedge clk);
        chk("reset_hold {pend,tgt,dir,door}", 32'({pending, target_floor, dir_up, door_open}),
            32'({10'h000, 4'd0, 1'b1, 1'b0}));
        call_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release {pend,tgt,dir,door}", 32'({pending, target_floor, dir_up, door_open}),
            32'({10'h000, 4'd0, 1'b1, 1'b0}));

        // Cycle vectors: {cur, call_valid, call_floor} -> {pending, target, dir_up, door_open}
        vecs.push_back(mk(0, 1, 5,  'h020, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  'h020, 5, 1, 0));
        vecs.push_back(mk(0, 1, 12, 'h020, 5, 1, 0));
        vecs.push_back(mk(3, 0, 0,  'h020, 5, 1, 0));
        vecs.push_back(mk(5, 1, 5,  'h000, 5, 1, 1));
        repeat (3) vecs.push_back(mk(5, 0, 0, 'h000, 5, 1, 1));
        repeat (2) vecs.push_back(mk(5, 0, 0, 'h000, 5, 1, 0));
        vecs.push_back(mk(5, 1, 2,  'h004, 5, 1, 0));
        vecs.push_back(mk(5, 0, 0,  'h004, 2, 0, 0));
        vecs.push_back(mk(4, 1, 3,  'h00C, 2, 0, 0));
        vecs.push_back(mk(4, 0, 0,  'h00C, 3, 0, 0));
        vecs.push_back(mk(3, 1, 7,  'h084, 3, 0, 1));
        vecs.push_back(mk(3, 1, 3,  'h084, 3, 0, 1));
        repeat (3) vecs.push_back(mk(3, 0, 0, 'h084, 3, 0, 1));
        vecs.push_back(mk(3, 0, 0,  'h084, 3, 0, 0));
        vecs.push_back(mk(3, 0, 0,  'h084, 2, 0, 0));
        vecs.push_back(mk(2, 0, 0,  'h080, 2, 0, 1));
        repeat (3) vecs.push_back(mk(2, 0, 0, 'h080, 2, 0, 1));
        vecs.push_back(mk(2, 0, 0,  'h080, 2, 0, 0));
        vecs.push_back(mk(2, 0, 0,  'h080, 7, 1, 0));
        vecs.push_back(mk(7, 0, 0,  'h000, 7, 1, 1));
        repeat (3) vecs.push_back(mk(7, 0, 0, 'h000, 7, 1, 1));
        vecs.push_back(mk(7, 0, 0,  'h000, 7, 1, 0));
        vecs.push_back(mk(7, 1, 7,  'h000, 7, 1, 1));
        vecs.push_back(mk(7, 1, 12, 'h000, 7, 1, 1));
        repeat (2) vecs.push_back(mk(7, 0, 0, 'h000, 7, 1, 1));
        vecs.push_back(mk(7, 0, 0,  'h000, 7, 1, 0));

        foreach (vecs[i]) begin
            current_floor = vecs[i].cur;
            call_valid    = vecs[i].cv;
            call_floor    = vecs[i].cf;
            e.pend = vecs[i].pend;
            e.tgt  = vecs[i].tgt;
            e.dir  = vecs[i].dir;
            e.door = vecs[i].door;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d {pend,tgt,dir,door}", i),
                32'({pending, target_floor, dir_up, door_open}), 32'({e.pend, e.tgt, e.dir, e.door}));
        end
        call_valid = 1'b0;

        // Retarget: car at 1 bound for 7, call 4 once the car reaches 2
        do_reset(4'd1);
        call_valid = 1'b1;
        call_floor = 4'd7;
        tick();
        call_valid = 1'b0;
        run_to_floor("retarget_reach2", 4'd2, 100);
        call_valid = 1'b1;
        call_floor = 4'd4;
        tick();
        call_valid = 1'b0;
        chk("retarget_pending", 32'(pending), 32'(10'h090));
        tick();
        chk("retarget_target", 32'(target_floor), 32'd4);
        arr_q.push_back(mka(4, 1));
        run_arrivals("retarget_arrive4", 200);
        repeat (5) @(negedge clk);
        chk("retarget_resume {tgt,dir}", 32'({target_floor, dir_up}), 32'({4'd7, 1'b1}));
        arr_q.push_back(mka(7, 1));
        run_arrivals("retarget_arrive7", 200);
        chk("retarget_final_pending", 32'(pending), 32'd0);

        // Reversal: car at 6 going up with {2,8} pending, call 3 while travelling
        do_reset(4'd6);
        call_valid = 1'b1;
        call_floor = 4'd8;
        tick();
        call_floor = 4'd2;
        tick();
        call_valid = 1'b0;
        chk("reversal_start {pend,tgt,dir}", 32'({pending, target_floor, dir_up}),
            32'({10'h104, 4'd8, 1'b1}));
        arr_q.push_back(mka(8, 1));
        arr_q.push_back(mka(3, 0));
        arr_q.push_back(mka(2, 0));
        run_to_floor("reversal_reach7", 4'd7, 100);
        call_valid = 1'b1;
        call_floor = 4'd3;
        tick();
        call_valid = 1'b0;
        run_arrivals("reversal_order", 600);
        chk("reversal_final_pending", 32'(pending), 32'd0);

        // Asynchronous reset while serving downward with calls pending
        repeat (6) @(negedge clk);
        call_valid = 1'b1;
        call_floor = 4'd1;
        @(negedge clk);
        call_floor = 4'd5;
        @(negedge clk);
        call_valid = 1'b0;
        chk("pre_reset {pend,tgt,dir}", 32'({pending, target_floor, dir_up}),
            32'({10'h022, 4'd1, 1'b0}));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset {pend,tgt,dir,door}", 32'({pending, target_floor, dir_up, door_open}),
               32'({10'h000, 4'd0, 1'b1, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
